// File: rtl/mac_stream_param.sv
// Streaming signed multiply-accumulate with a saturating accumulator. Define
// MAC_STREAM_RELU_EN to replace negative dot-product results with zero.
`timescale 1ns/1ps

module mac_stream_param #(
    parameter int WIDTH       = 14,
    parameter int MULT_STAGES = 2,
    parameter int ACC_WIDTH   = 2*WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_a,
    input  logic signed [WIDTH-1:0]     in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_f,
    output logic                        out_sat
);

    localparam int PW = 2*WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Handshakes: a beat transfers on a rising edge where valid and ready are
    // both 1. The whole pipeline freezes while a result waits unaccepted, so
    // in_ready is simply the inverse of that stall.
    logic stall;
    logic accept;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_full;

    logic signed [PW-1:0]  mult_q [MULT_STAGES];
    logic [MULT_STAGES-1:0] mult_v;
    logic [MULT_STAGES-1:0] mult_l;

    logic signed [ACC_WIDTH-1:0] prod_q;
    logic                        prod_v;
    logic                        prod_l;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        sticky_q;

    logic signed [ACC_WIDTH:0]   sum_w;
    logic                        ovf;
    logic signed [ACC_WIDTH-1:0] clamped;
    logic signed [ACC_WIDTH-1:0] result_f;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    assign a_ext     = PW'(in_a);
    assign b_ext     = PW'(in_b);
    assign prod_full = a_ext * b_ext;

    // One guard bit: the two top bits of the sum disagree exactly on overflow.
    assign sum_w = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_q);
    assign ovf   = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];

    always_comb begin
        clamped = sum_w[ACC_WIDTH-1:0];
        if (ovf) begin
            clamped = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

`ifdef MAC_STREAM_RELU_EN
    assign result_f = clamped[ACC_WIDTH-1] ? '0 : clamped;
`else
    assign result_f = clamped;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                mult_q[i] <= '0;
            end
            mult_v    <= '0;
            mult_l    <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            prod_l    <= 1'b0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            out_valid <= 1'b0;
            out_f     <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            mult_q[0] <= prod_full;
            mult_v[0] <= accept;
            mult_l[0] <= in_last;
            for (int i = 1; i < MULT_STAGES; i++) begin
                mult_q[i] <= mult_q[i-1];
                mult_v[i] <= mult_v[i-1];
                mult_l[i] <= mult_l[i-1];
            end

            prod_q <= ACC_WIDTH'(mult_q[MULT_STAGES-1]);
            prod_v <= mult_v[MULT_STAGES-1];
            prod_l <= mult_l[MULT_STAGES-1];

            // Not stalled: any held result is either absent or being taken now.
            out_valid <= 1'b0;
            if (prod_v) begin
                if (prod_l) begin
                    out_f     <= result_f;
                    out_sat   <= sticky_q | ovf;
                    out_valid <= 1'b1;
                    acc_q     <= '0;
                    sticky_q  <= 1'b0;
                end else begin
                    acc_q     <= clamped;
                    sticky_q  <= sticky_q | ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_param.sv
// Randomized and directed bench for mac_stream_param: a dot-product model fills
// an expected queue, and a monitor pops it at every output handshake.
`timescale 1ns/1ps

module tb_mac_stream_param;

    localparam int WIDTH = 14;
    localparam int MS    = 2;
    localparam int AW    = 2*WIDTH;
    localparam longint ACC_MAX_M = (longint'(1) <<< (AW-1)) - 1;
    localparam longint ACC_MIN_M = -(longint'(1) <<< (AW-1));
`ifdef MAC_STREAM_RELU_EN
    localparam longint BASIC_EXP = 0;
`else
    localparam longint BASIC_EXP = -7;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_a = '0;
    logic signed [WIDTH-1:0] in_b = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [AW-1:0]    out_f;
    logic                    out_sat;

    mac_stream_param #(.WIDTH(WIDTH), .MULT_STAGES(MS), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_sat(out_sat)
    );

    int checks = 0;
    int failures = 0;
    logic [AW:0] exp_q[$];
    longint acc_m = 0;
    bit sticky_m = 1'b0;
    bit rand_ready = 1'b0;
    bit ready_val = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain dot-product arithmetic with clamping
    task automatic model_accept(input int a, input int b, input bit last);
        longint s;
        bit sat;
        logic [AW:0] e;
        s = acc_m + longint'(a) * longint'(b);
        sat = 1'b0;
        if (s > ACC_MAX_M) begin s = ACC_MAX_M; sat = 1'b1; end
        if (s < ACC_MIN_M) begin s = ACC_MIN_M; sat = 1'b1; end
        if (last) begin
`ifdef MAC_STREAM_RELU_EN
            if (s < 0) s = 0;
`endif
            e = {sticky_m | sat, AW'(s)};
            exp_q.push_back(e);
            acc_m = 0;
            sticky_m = 1'b0;
        end else begin
            acc_m = s;
            sticky_m = sticky_m | sat;
        end
    endtask

    // driver
    task automatic send(input int a, input int b, input bit last);
        bit took = 1'b0;
        for (int t = 0; t < 300 && !took; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = WIDTH'(a);
            in_b = WIDTH'(b);
            in_last = last;
            #1;
            took = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (took) model_accept(a, b, last);
        else check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // monitor / scoreboard
    bit prev_stall = 1'b0;
    logic signed [AW-1:0] prev_f;
    logic prev_sat;
    always @(negedge clk) begin
        logic [AW:0] e;
        logic signed [AW-1:0] ef;
        #3;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_f", out_f, prev_f);
                check("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_f, 0);
                    if (out_f == 0) check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    ef = e[AW-1:0];
                    check("out_f", out_f, ef);
                    check("out_sat", out_sat, e[AW]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_f = out_f;
            prev_sat = out_sat;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_f", out_f, 0);
        check("rst_out_sat", out_sat, 0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // basic vector with latency and single-cycle pulse
        send(3, 2, 0);
        send(-4, 2, 0);
        send(5, -1, 1);
        @(posedge clk);
        @(posedge clk); #1;
        check("lat_edge3_low", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge4_high", out_valid, 1);
        check("basic_f", out_f, BASIC_EXP);
        check("basic_sat", out_sat, 0);
        @(posedge clk); #1;
        check("pulse_one_cycle", out_valid, 0);
        drain();

        // positive saturation then clean vector
        send(8191, 8191, 0);
        send(8191, 8191, 0);
        send(8191, 8191, 1);
        send(1, 1, 1);
        drain();

        // negative saturation
        send(-8192, 8191, 0);
        send(-8192, 8191, 0);
        send(-8192, 8191, 1);
        drain();

        // backpressure with single-element vectors
        ready_val = 1'b0;
        @(negedge clk); #1;
        send(2, 3, 1);
        send(4, 5, 1);
        send(6, 7, 1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_f", out_f, 6);
        ready_val = 1'b1;
        drain();

        // reset mid-vector
        send(100, 100, 0);
        @(negedge clk);
        reset = 1'b0;
        acc_m = 0;
        sticky_m = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_f", out_f, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        send(1, 2, 1);
        drain();

        // randomized stream with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            bit last;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 8191 : -8192)
                                            : int'($urandom_range(0, 16383)) - 8192;
            b = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 8191 : -8192)
                                            : int'($urandom_range(0, 16383)) - 8192;
            last = (i == 299) || ($urandom_range(0, 3) == 0);
            send(a, b, last);
        end
        rand_ready = 1'b0;
        ready_val = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_stream_param.md
MAC_STREAM_PARAM -- requirements
Module: mac_stream_param

Interface
REQ-001 SHALL have parameter WIDTH, default 14, signed operand width of in_a/in_b.
REQ-002 SHALL have parameter MULT_STAGES, default 2, register stages inside the multiplier (legal range 1..8).
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH, accumulator and result width (legal: ACC_WIDTH >= 2*WIDTH).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH each, signed operands.
REQ-008 SHALL have port in_last, input, 1, marking the final element of a dot-product vector.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-010 SHALL have port out_f, output, ACC_WIDTH, signed dot-product result.
REQ-011 SHALL have port out_sat, output, 1, set when any accumulation in the vector saturated.

Function
REQ-012 SHALL accept an element on a rising edge where in_valid and in_ready are both 1; no other edge accepts an element.
REQ-013 SHALL define stall = out_valid AND NOT out_ready, and SHALL drive in_ready = NOT stall.
REQ-014 SHALL freeze every pipeline stage (data, valid, last) while stall = 1; no element is lost or duplicated.
REQ-015 SHALL carry a valid bit and a last bit alongside each product through the MULT_STAGES multiplier stages, then one product register.
REQ-016 SHALL form the product as a full-precision 2*WIDTH signed product, sign-extended to ACC_WIDTH.
REQ-017 SHALL add a valid product to the accumulator with ACC_WIDTH+1 bit precision and clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-018 SHALL set an internal sticky saturation flag whenever the clamp in REQ-017 engages.
REQ-019 SHALL leave the accumulator unchanged on edges where the product register holds no valid product.
REQ-020 SHALL, when the product being accumulated carries last = 1, load the clamped sum into out_f, load (sticky flag OR this-cycle saturation) into out_sat, set out_valid, and clear the accumulator and sticky flag, all on the same edge.
REQ-021 SHALL, without stall, assert out_valid after the (MULT_STAGES+2)-th rising edge counted from and including the edge that accepted the last element.
REQ-022 SHALL clear out_valid on an edge with out_valid = 1 and out_ready = 1, unless a new result loads on that edge, in which case out_valid stays 1 with the new data.
REQ-023 SHALL hold out_f and out_sat stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL support back-to-back vectors, including single-element vectors (in_last = 1 on the first element), with no bubble cycles.

Reset
REQ-025 SHALL, while reset = 0, asynchronously clear all pipeline valid bits, the accumulator, the sticky flag, out_valid, out_f and out_sat to 0.
REQ-026 SHALL discard any partially accumulated vector when reset asserts mid-operation; the first vector after release starts from 0.
REQ-027 SHALL drive in_ready = 1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with macro MAC_STREAM_RELU_EN defined, replace a negative clamped result with 0 when loading out_f; out_sat is unaffected.
REQ-029 SHALL, without MAC_STREAM_RELU_EN, load the clamped signed result into out_f unmodified.

Verification (defaults: WIDTH=14, MULT_STAGES=2, ACC_WIDTH=28)
REQ-030 SHALL cover a basic vector: a={3,-4,5}, b={2,2,-1}, last on the 3rd, out_ready=1 -> out_f=-7, out_sat=0, out_valid high for 1 cycle, asserted after the 4th edge from the 3rd accept.
REQ-031 SHALL cover positive saturation: 3 elements of 8191*8191 -> out_f=134217727, out_sat=1; the next vector {1*1} -> out_f=1, out_sat=0.
REQ-032 SHALL cover negative saturation: 3 elements of -8192*8191 -> out_f=-134217728, out_sat=1.
REQ-033 SHALL cover backpressure: stream 3 single-element vectors {2*3},{4*5},{6*7} with out_ready=0 -> in_ready drops once out_valid=1, out_f holds 6; raising out_ready gives 6, 20, 42 in order with none lost.
REQ-034 SHALL cover reset mid-vector: accept {100*100} without last, pulse reset low, then send {1*2, last} -> out_f=2.
REQ-035 SHALL cover the macro: with MAC_STREAM_RELU_EN defined, the REQ-030 stimulus -> out_f=0, out_sat=0.
